// File: rtl/ram8_bank.sv
// Hack RAM8: eight WIDTH-bit registers built from Bit cells, a DMux tree that steers
// load to a single word, and a Mux8Way16-style tree that returns word[address].

module ram8_dmux (
    input  logic in,
    input  logic sel,
    output logic a,
    output logic b
);
    assign a = in & ~sel;
    assign b = in & sel;
endmodule

module ram8_mux2 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);
    assign out = sel ? b : a;
endmodule

module ram8_bit (
    input  logic clk,
    input  logic reset_n,
    input  logic in,
    input  logic load,
    output logic out
);
    logic d;

    // Without load, the DFF recirculates its own value.
    assign d = load ? in : out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) out <= 1'b0;
        else          out <= d;
    end
endmodule

module ram8_register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ram8_bit u_bit (
            .clk(clk), .reset_n(reset_n), .in(in[i]), .load(load), .out(out[i])
        );
    end
endmodule

module ram8_bank #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    output logic [WIDTH-1:0] out
);
    logic [1:0]       ld1;
    logic [3:0]       ld2;
    logic [7:0]       word_load;
    logic [WIDTH-1:0] word [8];
    logic [WIDTH-1:0] rd1  [4];
    logic [WIDTH-1:0] rd2  [2];

    // Load decode: address[2] first, then [1], then [0]; index k of each level
    // equals the address bits consumed so far.
    ram8_dmux u_ld0 (.in(load), .sel(address[2]), .a(ld1[0]), .b(ld1[1]));

    for (genvar i = 0; i < 2; i++) begin : g_ld1
        ram8_dmux u_dm (.in(ld1[i]), .sel(address[1]), .a(ld2[2*i]), .b(ld2[2*i+1]));
    end

    for (genvar j = 0; j < 4; j++) begin : g_ld2
        ram8_dmux u_dm (.in(ld2[j]), .sel(address[0]), .a(word_load[2*j]), .b(word_load[2*j+1]));
    end

    for (genvar k = 0; k < 8; k++) begin : g_word
        ram8_register #(.WIDTH(WIDTH)) u_reg (
            .clk(clk), .reset_n(reset_n), .in(in), .load(word_load[k]), .out(word[k])
        );
    end

    // Read tree: address[0] pairs adjacent words, then [1], then [2].
    for (genvar k = 0; k < 4; k++) begin : g_rd1
        ram8_mux2 #(.WIDTH(WIDTH)) u_mx (
            .a(word[2*k]), .b(word[2*k+1]), .sel(address[0]), .out(rd1[k])
        );
    end

    for (genvar k = 0; k < 2; k++) begin : g_rd2
        ram8_mux2 #(.WIDTH(WIDTH)) u_mx (
            .a(rd1[2*k]), .b(rd1[2*k+1]), .sel(address[1]), .out(rd2[k])
        );
    end

    ram8_mux2 #(.WIDTH(WIDTH)) u_rd3 (
        .a(rd2[0]), .b(rd2[1]), .sel(address[2]), .out(out)
    );
endmodule

// File: doc/ram8_bank.md
# ram8_bank

Eight-word, 16-bit register bank, the Hack RAM8 chip, built structurally from existing gate and chip primitives. It sits directly downstream of the 1-to-2 demultiplexer. A three-level tree of those demultiplexers, equivalent to DMux8Way, steers the `load` strobe to exactly one of eight word registers. A Mux8Way16 tree returns the addressed word. It is the leaf stage of the RAM64/RAM512/RAM4K/RAM16K hierarchy.

## Interface
- `WIDTH`, 16, word width in bits.
  - Only 16 is required by the memory hierarchy.
  - Other values must still elaborate.
- `clk` input, 1 bit, system clock; all state updates on the rising edge.
- `reset_n` input, 1 bit, asynchronous, active-low reset; clears all eight words.
- `in` input, `WIDTH` bits, write data.
- `load` input, 1 bit, write strobe; sampled on the rising `clk` edge.
- `address` input, 3 bits, word select for both write and read.
- `out` output, `WIDTH` bits, contents of word[`address`].

One clock; reset is asynchronous and active-low.

## Operation
- Storage: eight registers, word0–word7, each `WIDTH` bits.
  - Each register is a Register chip: one Bit cell per data bit.
  - Each Bit cell is a DFF plus a 2:1 hold/load mux.
- Load decode: `address[2]` splits `load` into two halves, then `address[1]`, then `address[0]`.
  - The decode uses the existing 1-to-2 demultiplexer, 7 instances in total.
  - Exactly one per-word load line is high when `load`=1; all are low when `load`=0.
- Write: on a rising `clk` edge with `reset_n`=1 and `load`=1, word[`address`] ← `in`.
  - The other seven words hold their values.
- Hold: with `load`=0, all words keep their value indefinitely.
- Read: `out` = word[`address`], purely combinational through the 8-way 16-bit mux tree.
  - The tree is `address[0]` at the first level, then `address[1]`, then `address[2]`.
  - There is no read latency and no output register.
- Reset: while `reset_n`=0, all words are 0, so `out`=0 for every `address`.
  - `load` and `clk` are ignored during reset.
- Reset asserted mid-write: the clear wins immediately and the pending write is lost.
- No state machine and no handshake. The bank is always ready; a write completes in the cycle it is presented.
- Address range: all 8 codes are valid. There is no wrap, overflow or out-of-range case.
- No X or Z is ever driven on `out` after the first reset.

## Timing
- Reset value of `out`: 0, asynchronously, within combinational delay of the `reset_n` falling edge.
- Write latency: 1 edge. The new value is visible on `out` (when `address` still selects it) after the rising edge that samples `load`=1.
- Read-during-write, same address:
  - Before the edge, `out` shows the old word.
  - After the edge, `out` shows `in` as sampled.
  - There is no write-through bypass.
- Read-during-write, different address: `out` shows the read address's stored word. It is unaffected by the write.
- Back-to-back writes: one per cycle, any address sequence, with no bubbles.
- Same address written on consecutive edges: the last write wins.
- Address change without `load`: `out` follows combinationally in the same cycle.
- Reset release: `reset_n` deassertion must meet recovery to `clk`.
  - The first edge after release may write.
  - The bench holds `load`=0 on the release edge.
- `in`/`load`/`address` changes between edges: no effect on storage.
- Setup and hold are relative to the rising edge only.

## Test plan
- Reset:
  - Preload all words with 0xFFFF.
  - Pulse `reset_n` low between clock edges.
  - Sweep `address` 0–7 → `out`=0x0000 for every address, with no clock edge needed.
- Walk write/read:
  - Write word k = 0x1111·(k+1) for k = 0–7 (word7 = 0x8888).
  - Then read 0–7 → `out` equals each value exactly.
  - The write phase takes 8 edges; reads are combinational.
- Isolation:
  - With all words at 0x0000, write 0xBEEF to address 5.
  - Read addresses 0–4 and 6–7 → 0x0000; address 5 → 0xBEEF.
  - Repeat for every address to prove one-hot load decode.
- Hold:
  - Write 0x1234 to address 3.
  - Run 20 edges with `load`=0, `in` toggling random values and `address` sweeping.
  - Word3 must still read 0x1234.
- Read-during-write:
  - Address 2 holds 0x00AA. Present `in`=0x5500, `load`=1, `address`=2.
  - `out`=0x00AA before the edge and 0x5500 after it.
  - Repeat with word 6 holding 0x0001 and a write to address 2. `out` at address 6 must remain 0x0001 throughout.
- Reset mid-operation:
  - Write 0xCAFE to address 7 on cycle n.
  - On cycle n+1, assert `reset_n` low coincident with `load`=1, `in`=0x1357.
  - `out`=0 for all addresses, and 0x1357 is never stored.
  - After release, with `load`=0, all words read 0.
